// File: rtl/fetch_decode_pipe_reg.sv
// Fetch->Decode pipeline register: main entry plus one skid entry, valid/ready handshake, stall and flush.
// Optional perf counters (StallCnt/FlushCnt) are built only when FD_PERF_CNT_EN is defined.
module fetch_decode_pipe_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h00000013),
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidF,
  output logic                  ReadyF,
  input  logic [DATA_WIDTH-1:0] RD,
  input  logic [ADDR_WIDTH-1:0] PCF,
  input  logic [ADDR_WIDTH-1:0] PC_PlusF,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic                  ValidD,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [ADDR_WIDTH-1:0] PCD,
  output logic [ADDR_WIDTH-1:0] PC_PlusD
`ifdef FD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  StallCnt,
  output logic [CNT_WIDTH-1:0]  FlushCnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // F side: in = ValidF && ReadyF. D side: out = ValidD && !StallD. ReadyF depends only on state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] main_instr, skid_instr;
  logic [ADDR_WIDTH-1:0] main_pc, skid_pc;
  logic [ADDR_WIDTH-1:0] main_pcp, skid_pcp;

  logic in_xfer, out_xfer;
  logic load_main_f, load_main_skid, load_skid;

  assign in_xfer  = ValidF && ReadyF;
  assign out_xfer = ValidD && !StallD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (FlushD) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (in_xfer) state_nxt = FULL;
        FULL: begin
          if (in_xfer && !out_xfer)      state_nxt = SKID;
          else if (!in_xfer && out_xfer) state_nxt = EMPTY;
        end
        SKID:    if (out_xfer) state_nxt = FULL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    ValidD         = (state != EMPTY);
    ReadyF         = (state != SKID);
    load_main_f    = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!FlushD) begin
      case (state)
        EMPTY:   load_main_f = in_xfer;
        FULL: begin
          load_main_f = in_xfer && out_xfer;
          load_skid   = in_xfer && !out_xfer;
        end
        SKID:    load_main_skid = out_xfer;
        default: ;
      endcase
    end
  end

  // Main entry keeps its pc fields after draining so PCD/PC_PlusD hold their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      main_pcp   <= '0;
    end else if (load_main_f) begin
      main_instr <= RD;
      main_pc    <= PCF;
      main_pcp   <= PC_PlusF;
    end else if (load_main_skid) begin
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
      main_pcp   <= skid_pcp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_pcp   <= '0;
    end else if (load_skid) begin
      skid_instr <= RD;
      skid_pc    <= PCF;
      skid_pcp   <= PC_PlusF;
    end
  end

  assign InstrD   = ValidD ? main_instr : NOP_INSTR;
  assign PCD      = main_pc;
  assign PC_PlusD = main_pcp;

`ifdef FD_PERF_CNT_EN
  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (ValidD && StallD && !(&StallCnt)) StallCnt <= StallCnt + CNT_WIDTH'(1);
      if (FlushD && !(&FlushCnt))           FlushCnt <= FlushCnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Self-checking bench for fetch_decode_pipe_reg against a 2-deep FIFO reference model.
// Define FD_PERF_CNT_EN to also build and check the perf counters (CNT_WIDTH=4).
module tb_fetch_decode_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int W  = DW + 2 * AW;
  localparam logic [DW-1:0] NOP = 32'h00000013;
`ifdef FD_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ValidF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic [DW-1:0] RD = '0;
  logic [AW-1:0] PCF = '0, PC_PlusF = '0;
  logic ReadyF, ValidD;
  logic [DW-1:0] InstrD;
  logic [AW-1:0] PCD, PC_PlusD;
`ifdef FD_PERF_CNT_EN
  logic [CW-1:0] StallCnt, FlushCnt;
`endif

  fetch_decode_pipe_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_INSTR(NOP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .ReadyF(ReadyF), .RD(RD), .PCF(PCF),
    .PC_PlusF(PC_PlusF), .StallD(StallD), .FlushD(FlushD), .ValidD(ValidD),
    .InstrD(InstrD), .PCD(PCD), .PC_PlusD(PC_PlusD)
`ifdef FD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of capacity 2 holding {instr, pc, pc_plus}; front is what decode sees.
  logic [W-1:0] exp_q[$];
  logic [AW-1:0] last_pc = '0, last_pcp = '0;
  int stall_cnt_m = 0, flush_cnt_m = 0;
  int n_checks = 0, n_fail = 0;

  logic          exp_valid, exp_ready;
  logic [DW-1:0] exp_instr;
  logic [AW-1:0] exp_pc, exp_pcp;

  task automatic compute_exp();
    exp_valid = (exp_q.size() > 0);
    exp_ready = (exp_q.size() < 2);
    exp_instr = exp_valid ? exp_q[0][W-1 -: DW] : NOP;
    exp_pc    = last_pc;
    exp_pcp   = last_pcp;
  endtask

  // One clock: drive inputs on the falling edge, advance the model, land 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [DW-1:0] i, input logic [AW-1:0] p,
                       input logic [AW-1:0] pp, input logic s, input logic f);
    int sz;
    @(negedge clk);
    ValidF = v; RD = i; PCF = p; PC_PlusF = pp; StallD = s; FlushD = f;
    sz = exp_q.size();
    if (sz > 0 && s) stall_cnt_m = (stall_cnt_m == (1 << CW) - 1) ? stall_cnt_m : stall_cnt_m + 1;
    if (f) flush_cnt_m = (flush_cnt_m == (1 << CW) - 1) ? flush_cnt_m : flush_cnt_m + 1;
    if (f) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && !s) void'(exp_q.pop_front());
      if (v && sz < 2) exp_q.push_back({i, p, pp});
    end
    if (exp_q.size() > 0) begin
      last_pc  = exp_q[0][2*AW-1 -: AW];
      last_pcp = exp_q[0][AW-1:0];
    end
    @(posedge clk);
    #1;
    compute_exp();
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_pc = '0; last_pcp = '0;
    stall_cnt_m = 0; flush_cnt_m = 0;
    compute_exp();
  endtask

  task automatic test_reset();
    #1;
    model_reset();
    n_checks += 4;
    if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ValidD); end
    if (ReadyF !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ReadyF); end
    if (InstrD !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", InstrD, NOP); end
    if (PCD !== '0 || PC_PlusD !== '0) begin n_fail++; $display("FAIL reset_pc: got %h/%h want 0/0", PCD, PC_PlusD); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, $urandom, AW'(4 * k), AW'(4 * k + 4), 1'b0, 1'b0);
      n_checks += 4;
      if (ValidD !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, ValidD); end
      if (ReadyF !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", k, ReadyF); end
      if (PCD !== AW'(4 * k) || PC_PlusD !== AW'(4 * k + 4)) begin
        n_fail++; $display("FAIL stream_pc[%0d]: got %h/%h want %h/%h", k, PCD, PC_PlusD, 4 * k, 4 * k + 4);
      end
      if (InstrD !== exp_instr) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, InstrD, exp_instr); end
    end
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (ValidD !== 1'b0 || InstrD !== NOP) begin n_fail++; $display("FAIL stream_drain: got %b/%h want 0/%h", ValidD, InstrD, NOP); end
  endtask

  task automatic test_stall_fill();
    cycle(1'b1, 32'hAAAA0010, 32'h10, 32'h14, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA0014, 32'h14, 32'h18, 1'b1, 1'b0);
    n_checks += 2;
    if (ReadyF !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", ReadyF); end
    if (PCD !== 32'h10 || ValidD !== 1'b1) begin n_fail++; $display("FAIL fill_hold: got %h/%b want 10/1", PCD, ValidD); end
    cycle(1'b1, 32'hAAAA0018, 32'h18, 32'h1C, 1'b1, 1'b0);
    n_checks++;
    if (PCD !== 32'h10 || ReadyF !== 1'b0) begin n_fail++; $display("FAIL fill_still: got %h/%b want 10/0", PCD, ReadyF); end
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    n_checks += 2;
    if (PCD !== 32'h14 || InstrD !== 32'hAAAA0014) begin n_fail++; $display("FAIL release_pc: got %h/%h want 14/aaaa0014", PCD, InstrD); end
    if (ReadyF !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", ReadyF); end
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (ValidD !== 1'b0 || PCD !== 32'h14) begin n_fail++; $display("FAIL release_drain: got %b/%h want 0/14", ValidD, PCD); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'hBBBB0100, 32'h100, 32'h104, 1'b1, 1'b0);
    cycle(1'b1, 32'hBBBB0104, 32'h104, 32'h108, 1'b1, 1'b0);
    cycle(1'b1, 32'hBBBB0108, 32'h108, 32'h10C, 1'b1, 1'b1);
    n_checks += 3;
    if (ValidD !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", ValidD); end
    if (InstrD !== NOP) begin n_fail++; $display("FAIL flush_instr: got %h want %h", InstrD, NOP); end
    if (ReadyF !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", ReadyF); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== exp_pc) begin
        n_fail++; $display("FAIL flush_ghost[%0d]: got %b/%h/%h want 0/%h/%h", k, ValidD, InstrD, PCD, NOP, exp_pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      cycle(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
      n_checks += 3;
      if (ValidD !== 1'b1 || ReadyF !== 1'b1) begin n_fail++; $display("FAIL b2b_hs[%0d]: got %b/%b want 1/1", k, ValidD, ReadyF); end
      if (InstrD !== exp_instr) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h want %h", k, InstrD, exp_instr); end
      if (PCD !== exp_pc || PC_PlusD !== exp_pcp) begin
        n_fail++; $display("FAIL b2b_pc[%0d]: got %h/%h want %h/%h", k, PCD, PC_PlusD, exp_pc, exp_pcp);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      n_checks += 4;
      if (ValidD !== exp_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, ValidD, exp_valid); end
      if (ReadyF !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, ReadyF, exp_ready); end
      if (InstrD !== exp_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", k, InstrD, exp_instr); end
      if (PCD !== exp_pc || PC_PlusD !== exp_pcp) begin
        n_fail++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h/%h", k, PCD, PC_PlusD, exp_pc, exp_pcp);
      end
`ifdef FD_PERF_CNT_EN
      n_checks++;
      if (StallCnt !== CW'(stall_cnt_m) || FlushCnt !== CW'(flush_cnt_m)) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", k, StallCnt, FlushCnt, stall_cnt_m, flush_cnt_m);
      end
`endif
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 32'hCCCC0200, 32'h200, 32'h204, 1'b1, 1'b0);
    cycle(1'b1, 32'hCCCC0204, 32'h204, 32'h208, 1'b1, 1'b0);
    @(negedge clk);
    ValidF = 1'b0; StallD = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks += 4;
    if (ValidD !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", ValidD); end
    if (ReadyF !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", ReadyF); end
    if (InstrD !== NOP) begin n_fail++; $display("FAIL mid_rst_instr: got %h want %h", InstrD, NOP); end
    if (PCD !== '0 || PC_PlusD !== '0) begin n_fail++; $display("FAIL mid_rst_pc: got %h/%h want 0/0", PCD, PC_PlusD); end
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (ValidD !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ghost: got %b want 0", ValidD); end
    cycle(1'b1, 32'hDDDD0300, 32'h300, 32'h304, 1'b0, 1'b0);
    n_checks++;
    if (ValidD !== 1'b1 || PCD !== 32'h300) begin n_fail++; $display("FAIL mid_rst_first: got %b/%h want 1/300", ValidD, PCD); end
  endtask

`ifdef FD_PERF_CNT_EN
  task automatic test_perf_cnt();
    @(negedge clk);
    ValidF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (StallCnt !== '0 || FlushCnt !== '0) begin n_fail++; $display("FAIL cnt_reset: got %0d/%0d want 0/0", StallCnt, FlushCnt); end
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h1, 32'h400, 32'h404, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (StallCnt !== 4'd15) begin n_fail++; $display("FAIL stall_sat: got %0d want 15", StallCnt); end
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    n_checks += 2;
    if (FlushCnt !== 4'd3) begin n_fail++; $display("FAIL flush_cnt: got %0d want 3", FlushCnt); end
    if (StallCnt !== 4'd15) begin n_fail++; $display("FAIL stall_hold: got %0d want 15", StallCnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_midstream();
`ifdef FD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
